// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between icache refills and dcache refills/write-backs as WORDS-beat bursts; define CACHE_ARB_FIXED_PRIO_EN to make ties always go to dcache.
// Latency: request in IDLE -> mem_valid next cycle; done one cycle after the last write acceptance or last read response.
// Backpressure: mem_ready low stalls the beat with mem_valid/mem_addr/mem_we held; dc_wready marks each consumed write beat.
module cache_mem_arbiter #(
  parameter int WORDS  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_rvalid,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_wready,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_rvalid,
  output logic              dc_done,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WORD_SH = $clog2(WORDS);
  localparam int BYTE_SH = $clog2(DATA_W/8);
  localparam int OFF_W   = WORD_SH + BYTE_SH;
  localparam int CW      = WORD_SH + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                   state, state_nxt;
  logic                     owner_dc;
  logic                     we_q;
  logic [ADDR_W-OFF_W-1:0]  base_hi;
  logic [CW-1:0]            issue_cnt;
  logic [CW-1:0]            resp_cnt;
  logic [OFF_W-1:0]         beat_off;
  logic                     grant_vld;
  logic                     grant_dc;
  logic                     accept;
  logic                     resp_hit;
  logic                     last_issue;
  logic                     last_resp;
  logic                     unused_addr_bits;

  assign unused_addr_bits = ^{ic_addr[OFF_W-1:0], dc_addr[OFF_W-1:0]};
  assign grant_vld = ic_req || dc_req;

`ifdef CACHE_ARB_FIXED_PRIO_EN
  assign grant_dc = dc_req;
`else
  logic last_dc;

  // Ties go to whichever side was not served last; dcache counts as last out of reset.
  assign grant_dc = dc_req && (!ic_req || !last_dc);

  always_ff @(posedge CLK) begin
    if (reset)
      last_dc <= 1'b1;
    else if (state == DONE)
      last_dc <= owner_dc;
  end
`endif

  assign accept     = (state == ISSUE) && mem_ready;
  assign resp_hit   = mem_rvalid && !we_q && (state == ISSUE || state == DRAIN)
                      && (resp_cnt != CW'(WORDS));
  assign last_issue = accept && (issue_cnt == CW'(WORDS-1));
  assign last_resp  = resp_hit && (resp_cnt == CW'(WORDS-1));
  // Offset comes only from the low counter bits so the beat address never carries into the block base.
  assign beat_off   = OFF_W'(issue_cnt[WORD_SH-1:0]) << BYTE_SH;

  always_ff @(posedge CLK) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    dc_wready = 1'b0;
    ic_rvalid = 1'b0;
    dc_rvalid = 1'b0;
    ic_rdata  = '0;
    dc_rdata  = '0;
    ic_done   = 1'b0;
    dc_done   = 1'b0;
    case (state)
      IDLE:  if (grant_vld) state_nxt = ISSUE;
      ISSUE: begin
        mem_valid = 1'b1;
        mem_we    = we_q;
        mem_addr  = {base_hi, beat_off};
        mem_wdata = we_q ? dc_wdata : '0;
        dc_wready = we_q && mem_ready;
        if (last_issue)
          state_nxt = (we_q || last_resp) ? DONE : DRAIN;
      end
      DRAIN: if (last_resp) state_nxt = DONE;
      DONE: begin
        ic_done   = !owner_dc;
        dc_done   = owner_dc;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (resp_hit) begin
      ic_rvalid = !owner_dc;
      dc_rvalid = owner_dc;
      ic_rdata  = mem_rdata;
      dc_rdata  = mem_rdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      owner_dc  <= 1'b0;
      we_q      <= 1'b0;
      base_hi   <= '0;
      issue_cnt <= '0;
      resp_cnt  <= '0;
    end else if (state == IDLE && grant_vld) begin
      owner_dc  <= grant_dc;
      we_q      <= grant_dc && dc_we;
      base_hi   <= grant_dc ? dc_addr[ADDR_W-1:OFF_W] : ic_addr[ADDR_W-1:OFF_W];
      issue_cnt <= '0;
      resp_cnt  <= '0;
    end else begin
      if (accept)
        issue_cnt <= issue_cnt + 1'b1;
      if (resp_hit)
        resp_cnt <= resp_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: a memory model with configurable ready/latency plus a burst-level
// scoreboard; grant order comes from a table or from a request-queue model of the arbitration rule.
module tb_cache_mem_arbiter;
  localparam int WORDS  = 8;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              CLK = 1'b0;
  logic              reset;
  logic              ic_req, dc_req, dc_we, dc_wready;
  logic [ADDR_W-1:0] ic_addr, dc_addr, mem_addr;
  logic [DATA_W-1:0] ic_rdata, dc_rdata, dc_wdata, mem_wdata, mem_rdata;
  logic              ic_rvalid, ic_done, dc_rvalid, dc_done;
  logic              mem_valid, mem_ready, mem_we, mem_rvalid;

  cache_mem_arbiter #(.WORDS(WORDS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK(CLK), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_rvalid(ic_rvalid), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_wready(dc_wready),
    .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid), .dc_done(dc_done),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  typedef struct {
    int          nic;
    int          ndc;
    bit          we;
    logic [31:0] ia;
    logic [31:0] da;
    int          rm;
    int          lt;
    logic [7:0]  ord_rr;
    logic [7:0]  ord_fx;
    int          nb;
  } vec_t;

  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  rsp_t        rq[$];
  bit          ic_want = 0, dc_want = 0, we_w = 0;
  logic [31:0] ia_w = '0, da_w = '0;
  int          rmode = 0, lat = 1, wbeat = 0, inj_cyc = -1;
  bit          m_last = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] wdat(input logic [31:0] base, input int beat);
    return (base ^ 32'h5A00_0000) + 32'(beat) * 32'h0101_0001;
  endfunction

  function automatic logic [31:0] rdat(input logic [31:0] addr);
    return ~addr ^ 32'h0033_CC00;
  endfunction

  function automatic int outs_set();
    return $countones({ic_rdata, ic_rvalid, ic_done, dc_wready, dc_rdata, dc_rvalid, dc_done,
                       mem_valid, mem_we, mem_addr, mem_wdata});
  endfunction

  // Arbitration rule as a plain request-count simulation: tie -> side not served last (or dcache).
  function automatic void model_order(input int nic, input int ndc, input bit last,
                                      output logic [7:0] ord, output int nb);
    bit pick;
    nb  = 0;
    ord = '0;
    while (nic > 0 || ndc > 0) begin
`ifdef CACHE_ARB_FIXED_PRIO_EN
      if (nic > 0 && ndc > 0) pick = 1'b1;
`else
      if (nic > 0 && ndc > 0) pick = !last;
`endif
      else pick = (ndc > 0);
      ord[nb] = pick;
      nb++;
      last = pick;
      if (pick) ndc--; else nic--;
    end
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    if (cyc == inj_cyc) dc_want = 1'b1;
    ic_req   = ic_want;
    dc_req   = dc_want;
    ic_addr  = ia_w;
    dc_addr  = da_w;
    dc_we    = we_w;
    dc_wdata = wdat(da_w & ~32'h1F, wbeat);
    case (rmode)
      0:       mem_ready = 1'b1;
      1:       mem_ready = (cyc[0] == 1'b0);
      default: mem_ready = ($urandom_range(0, 99) < 60);
    endcase
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rdat(rq[0].addr);
      void'(rq.pop_front());
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
    end
    @(negedge CLK);
    if (mem_valid && mem_ready && !mem_we) rq.push_back('{mem_addr, cyc + lat});
    if (dc_wready) wbeat++;
  endtask

  task automatic run_burst(input bit own, input bit we, input logic [31:0] addr,
                           input int first_cyc, output int d);
    logic [31:0] base, p_addr, p_wdata;
    logic        p_we, prev_stall, exp_rv, exp_done;
    int          acc, resp, last_ev;
    bit          seen;
    base = addr & ~32'h1F;
    wbeat = 0; acc = 0; resp = 0; last_ev = -1; seen = 0; prev_stall = 0; d = cyc;
    p_addr = '0; p_wdata = '0; p_we = 0;
    for (int t = 0; t < 400 && !seen; t++) begin
      tick();
      if (cyc < first_cyc) chk("gap_no_valid", mem_valid, 1'b0);
      if (cyc == first_cyc) chk("start_latency", mem_valid, 1'b1);
      chk("wready", dc_wready, mem_valid && mem_ready && mem_we);
      if (prev_stall) begin
        chk("stall_valid", mem_valid, 1'b1);
        chk("stall_addr", mem_addr, p_addr);
        chk("stall_we", mem_we, p_we);
        if (we) chk("stall_wdata", mem_wdata, p_wdata);
      end
      if (mem_valid && mem_ready && acc < WORDS) begin
        chk("beat_addr", mem_addr, base + 32'(acc) * 4);
        chk("beat_we", mem_we, we);
        if (we) chk("beat_wdata", mem_wdata, wdat(base, acc));
        acc++;
        if (acc == WORDS && we) last_ev = cyc;
      end
      exp_rv = !we && mem_rvalid && resp < WORDS;
      chk("ic_rvalid", ic_rvalid, exp_rv && !own);
      chk("dc_rvalid", dc_rvalid, exp_rv && own);
      if (exp_rv) begin
        chk("ic_rdata", ic_rdata, rdat(base + 32'(resp) * 4));
        chk("dc_rdata", dc_rdata, rdat(base + 32'(resp) * 4));
        resp++;
        if (resp == WORDS) last_ev = cyc;
      end
      exp_done = (last_ev >= 0) && (cyc == last_ev + 1);
      chk("ic_done", ic_done, exp_done && !own);
      chk("dc_done", dc_done, exp_done && own);
      if (exp_done) begin
        seen = 1;
        d = cyc;
      end
      prev_stall = mem_valid && !mem_ready;
      p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
    end
    if (!seen) chk("burst_timeout", 32'(last_ev), 32'(cyc - 1));
  endtask

  task automatic run_episode(input int nic, input int ndc, input bit we, input logic [31:0] ia,
                             input logic [31:0] da, input int rm, input int lt,
                             input logic [7:0] ord, input int nb);
    int  ic_left, dc_left, first, d;
    bit  own;
    rmode = rm; lat = lt; we_w = we; ia_w = ia; da_w = da;
    ic_left = nic; dc_left = ndc;
    ic_want = (nic > 0); dc_want = (ndc > 0);
    first = cyc + 2;
    for (int k = 0; k < nb; k++) begin
      own = ord[k];
      run_burst(own, own && we, own ? da : ia, first, d);
      if (own) dc_left--; else ic_left--;
      ic_want = (ic_left > 0);
      dc_want = (dc_left > 0);
      m_last  = own;
      first   = d + 2;
    end
    repeat (2) begin
      tick();
      chk("idle_after", mem_valid, 1'b0);
    end
  endtask

  vec_t tbl[6];

  initial begin
    int          d, cnt, nb, nic, ndc;
    logic [7:0]  ord;
    tbl[0] = '{1, 0, 1'b0, 32'h0000_1004, 32'h0,          0, 2, 8'b0,   8'b0,   1};
    tbl[1] = '{0, 1, 1'b1, 32'h0,          32'h0000_2000, 1, 1, 8'b1,   8'b1,   1};
    tbl[2] = '{1, 1, 1'b0, 32'h0000_3000, 32'h0000_4008, 2, 3, 8'b10,  8'b01,  2};
    tbl[3] = '{2, 1, 1'b1, 32'h0000_5000, 32'h0000_6000, 0, 1, 8'b010, 8'b001, 3};
    tbl[4] = '{1, 2, 1'b0, 32'h0000_7010, 32'h0000_7FFC, 1, 4, 8'b101, 8'b011, 3};
    tbl[5] = '{1, 0, 1'b0, 32'hFFFF_FFF4, 32'h0,          2, 2, 8'b0,   8'b0,   1};

    reset = 1'b1;
    ic_req = 0; dc_req = 0; dc_we = 0; ic_addr = '0; dc_addr = '0; dc_wdata = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    repeat (3) tick();
    chk("reset_outputs", outs_set(), 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
`ifdef CACHE_ARB_FIXED_PRIO_EN
      ord = tbl[i].ord_fx;
`else
      ord = tbl[i].ord_rr;
`endif
      run_episode(tbl[i].nic, tbl[i].ndc, tbl[i].we, tbl[i].ia, tbl[i].da,
                  tbl[i].rm, tbl[i].lt, ord, tbl[i].nb);
    end

    // dcache request arriving mid icache burst waits for the icache done.
    rmode = 0; lat = 2; ia_w = 32'h0000_8000; da_w = 32'h0000_9000; we_w = 1'b1;
    ic_want = 1'b1;
    inj_cyc = cyc + 4;
    run_burst(1'b0, 1'b0, 32'h0000_8000, cyc + 2, d);
    ic_want = 1'b0;
    inj_cyc = -1;
    run_burst(1'b1, 1'b1, 32'h0000_9000, d + 2, d);
    dc_want = 1'b0;
    m_last = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 16; i++) begin
      nic = $urandom_range(0, 2);
      ndc = $urandom_range(0, 2);
      if (nic == 0 && ndc == 0) nic = 1;
      model_order(nic, ndc, m_last, ord, nb);
      run_episode(nic, ndc, 1'($urandom_range(0, 1)), $urandom, $urandom,
                  $urandom_range(0, 2), $urandom_range(1, 4), ord, nb);
    end

    // Reset after three read responses: burst abandoned, late responses ignored.
    rmode = 0; lat = 4; ia_w = 32'h0000_A000; ic_want = 1'b1; cnt = 0;
    for (int t = 0; t < 60 && cnt < 3; t++) begin
      tick();
      if (ic_rvalid) cnt++;
    end
    chk("rst_wait_resp", cnt, 3);
    reset = 1'b1;
    ic_want = 1'b0;
    tick();
    chk("rst_mid_outputs", outs_set(), 0);
    reset = 1'b0;
    repeat (8) begin
      tick();
      chk("late_rsp_ignored", {ic_rvalid, dc_rvalid, ic_done, dc_done, mem_valid}, 5'b0);
    end
    rq.delete();
    m_last = 1'b1;
    run_episode(1, 0, 1'b0, 32'h0000_A004, 32'h0, 0, 2, 8'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
